// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit pipelined core.
// Holds datapath widths and the memory/writeback control bundle.
package cpu_pkg;

  localparam int DW = 16;
  localparam int RW = 3;

  typedef struct packed {
    logic mem_en;
    logic mem_wr;
    logic reg_wr;
    logic halt;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/store_bypass.sv
// Store-data forward: pick writeback data over the
// register-file copy when a store reads the reg being written.
module store_bypass #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          is_store,
  input  logic          wb_reg_wr,
  input  logic [RW-1:0] wb_rd,
  input  logic [RW-1:0] rs2,
  input  logic [DW-1:0] wb_data,
  input  logic [DW-1:0] r2,
  output logic [DW-1:0] data
);

  logic hit;

  // Forward when writeback targets the store's data register
  always_comb begin
    hit  = is_store && wb_reg_wr && (wb_rd == rs2);
    data = hit ? wb_data : r2;
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with stall, deferred flush,
// halt freeze and store-data bypass from writeback.
module ex_mem_pipe #(
  parameter int DW = cpu_pkg::DW,
  parameter int RW = cpu_pkg::RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_alu_out,
  input  logic          ex_zero,
  input  logic          ex_ofl,
  input  logic [DW-1:0] ex_r2,
  input  logic [RW-1:0] ex_rs2,
  input  logic          ex_mem_en,
  input  logic          ex_mem_wr,
  input  logic          ex_reg_wr,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_halt,
  input  logic [DW-1:0] ex_pc2,
  input  logic          wb_reg_wr,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic          mem_valid,
  output logic [DW-1:0] alu_out,
  output logic          alu_zero,
  output logic          alu_ofl,
  output logic [DW-1:0] r2,
  output logic          mem_en,
  output logic          mem_wr,
  output logic          reg_wr,
  output logic [RW-1:0] rd,
  output logic          HALT,
  output logic [DW-1:0] pc2,
  output logic          halted
);

  import cpu_pkg::*;

  logic          valid_q;
  logic [DW-1:0] alu_q;
  logic          zero_q;
  logic          ofl_q;
  logic [DW-1:0] r2_q;
  logic [RW-1:0] rs2_q;
  ctrl_t         ctrl_q;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] pc2_q;
  logic          flush_pend;
  logic          halted_q;

  ctrl_t         ex_ctrl;
  logic          bubble;
  logic          held_store;
  logic [DW-1:0] load_r2;
  logic [DW-1:0] hold_r2;

  // Qualify execute controls and decide whether this load is a bubble
  always_comb begin
    ex_ctrl.mem_en = ex_mem_en & ex_valid;
    ex_ctrl.mem_wr = ex_mem_wr & ex_valid;
    ex_ctrl.reg_wr = ex_reg_wr & ex_valid;
    ex_ctrl.halt   = ex_halt & ex_valid;
    bubble     = flush | flush_pend | halted_q;
    held_store = valid_q & ctrl_q.mem_en & ctrl_q.mem_wr;
  end

  store_bypass #(.DW(DW), .RW(RW)) u_load_byp (
    .is_store  (ex_mem_en & ex_mem_wr),
    .wb_reg_wr (wb_reg_wr),
    .wb_rd     (wb_rd),
    .rs2       (ex_rs2),
    .wb_data   (wb_data),
    .r2        (ex_r2),
    .data      (load_r2)
  );

  store_bypass #(.DW(DW), .RW(RW)) u_hold_byp (
    .is_store  (held_store),
    .wb_reg_wr (wb_reg_wr),
    .wb_rd     (wb_rd),
    .rs2       (rs2_q),
    .wb_data   (wb_data),
    .r2        (r2_q),
    .data      (hold_r2)
  );

  // Pipeline payload: hold (refreshing store data), bubble, or load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      zero_q  <= 1'b0;
      ofl_q   <= 1'b0;
      r2_q    <= '0;
      rs2_q   <= '0;
      ctrl_q  <= CTRL_BUBBLE;
      rd_q    <= '0;
      pc2_q   <= '0;
    end else if (stall) begin
      r2_q <= hold_r2;
    end else if (bubble) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      zero_q  <= 1'b0;
      ofl_q   <= 1'b0;
      r2_q    <= '0;
      rs2_q   <= '0;
      ctrl_q  <= CTRL_BUBBLE;
      rd_q    <= '0;
      pc2_q   <= '0;
    end else begin
      valid_q <= ex_valid;
      alu_q   <= ex_alu_out;
      zero_q  <= ex_zero;
      ofl_q   <= ex_ofl;
      r2_q    <= load_r2;
      rs2_q   <= ex_rs2;
      ctrl_q  <= ex_ctrl;
      rd_q    <= ex_rd;
      pc2_q   <= ex_pc2;
    end
  end

  // Deferred flush across a stall and sticky halt after a valid HALT load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_pend <= 1'b0;
      halted_q   <= 1'b0;
    end else if (stall) begin
      if (flush) flush_pend <= 1'b1;
    end else begin
      flush_pend <= 1'b0;
      if (!bubble && ex_valid && ex_halt) halted_q <= 1'b1;
    end
  end

  // Drive outputs; controls are masked by the valid bit
  always_comb begin
    mem_valid = valid_q;
    alu_out   = alu_q;
    alu_zero  = zero_q;
    alu_ofl   = ofl_q;
    r2        = r2_q;
    mem_en    = ctrl_q.mem_en & valid_q;
    mem_wr    = ctrl_q.mem_wr & valid_q;
    reg_wr    = ctrl_q.reg_wr & valid_q;
    HALT      = ctrl_q.halt & valid_q;
    rd        = rd_q;
    pc2       = pc2_q;
    halted    = halted_q;
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for the EX/MEM pipeline register.
// Linear steps with hand-computed expectations.
module tb_ex_mem_pipe;

  logic        clk = 0;
  logic        rst = 0;
  logic        stall = 0;
  logic        flush = 0;
  logic        ex_valid = 0;
  logic [15:0] ex_alu_out = 0;
  logic        ex_zero = 0;
  logic        ex_ofl = 0;
  logic [15:0] ex_r2 = 0;
  logic [2:0]  ex_rs2 = 0;
  logic        ex_mem_en = 0;
  logic        ex_mem_wr = 0;
  logic        ex_reg_wr = 0;
  logic [2:0]  ex_rd = 0;
  logic        ex_halt = 0;
  logic [15:0] ex_pc2 = 0;
  logic        wb_reg_wr = 0;
  logic [2:0]  wb_rd = 0;
  logic [15:0] wb_data = 0;

  logic        mem_valid;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic        alu_ofl;
  logic [15:0] r2;
  logic        mem_en;
  logic        mem_wr;
  logic        reg_wr;
  logic [2:0]  rd;
  logic        HALT;
  logic [15:0] pc2;
  logic        halted;

  int checks = 0;
  int errors = 0;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
    .ex_zero(ex_zero), .ex_ofl(ex_ofl), .ex_r2(ex_r2),
    .ex_rs2(ex_rs2), .ex_mem_en(ex_mem_en),
    .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr),
    .ex_rd(ex_rd), .ex_halt(ex_halt), .ex_pc2(ex_pc2),
    .wb_reg_wr(wb_reg_wr), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_valid(mem_valid), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_ofl(alu_ofl), .r2(r2),
    .mem_en(mem_en), .mem_wr(mem_wr), .reg_wr(reg_wr),
    .rd(rd), .HALT(HALT), .pc2(pc2), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_valid", mem_valid, 0);
    chk("rst_alu", alu_out, 0);
    chk("rst_halted", halted, 0);
    step();
    rst = 1;

    // pass-through
    ex_valid = 1; ex_alu_out = 16'h1234; ex_mem_en = 1;
    ex_rd = 5; ex_pc2 = 16'h0010; ex_zero = 1; ex_reg_wr = 1;
    step();
    chk("pt_alu", alu_out, 16'h1234);
    chk("pt_mem_en", mem_en, 1);
    chk("pt_mem_wr", mem_wr, 0);
    chk("pt_reg_wr", reg_wr, 1);
    chk("pt_rd", rd, 5);
    chk("pt_valid", mem_valid, 1);
    chk("pt_zero", alu_zero, 1);
    chk("pt_pc2", pc2, 16'h0010);

    // stall with flush in the middle
    ex_alu_out = 16'h00AA; ex_mem_en = 0; ex_zero = 0;
    ex_reg_wr = 0;
    step();
    chk("st_load", alu_out, 16'h00AA);
    stall = 1; ex_alu_out = 16'h0BBB;
    step();
    chk("st_c1", alu_out, 16'h00AA);
    flush = 1;
    step();
    chk("st_c2", alu_out, 16'h00AA);
    flush = 0;
    step();
    chk("st_c3", alu_out, 16'h00AA);
    chk("st_c3_valid", mem_valid, 1);
    stall = 0; ex_mem_en = 1;
    step();
    chk("fl_bub_valid", mem_valid, 0);
    chk("fl_bub_mem_en", mem_en, 0);
    chk("fl_bub_alu", alu_out, 0);
    ex_alu_out = 16'h0CCC;
    step();
    chk("fl_after_alu", alu_out, 16'h0CCC);
    chk("fl_after_valid", mem_valid, 1);
    chk("fl_after_mem_en", mem_en, 1);

    // store bypass at load
    ex_mem_wr = 1; ex_rs2 = 3; ex_r2 = 16'h1111;
    wb_reg_wr = 1; wb_rd = 3; wb_data = 16'hBEEF;
    step();
    chk("byp_hit", r2, 16'hBEEF);
    chk("byp_mem_wr", mem_wr, 1);
    wb_rd = 4;
    step();
    chk("byp_miss", r2, 16'h1111);

    // refresh of held store under stall
    wb_reg_wr = 0; ex_rs2 = 2; ex_r2 = 16'h2222;
    ex_alu_out = 16'h0300;
    step();
    chk("rf_load", r2, 16'h2222);
    stall = 1; wb_reg_wr = 1; wb_rd = 2; wb_data = 16'h5A5A;
    ex_alu_out = 16'h0999;
    step();
    chk("rf_r2", r2, 16'h5A5A);
    chk("rf_alu", alu_out, 16'h0300);
    wb_reg_wr = 0; stall = 0;
    ex_mem_en = 0; ex_mem_wr = 0;

    // reset while a flush is pending
    stall = 1; flush = 1;
    step();
    rst = 0;
    #1;
    chk("ar_valid", mem_valid, 0);
    chk("ar_alu", alu_out, 0);
    chk("ar_r2", r2, 0);
    #1;
    rst = 1; stall = 0; flush = 0;
    ex_alu_out = 16'h0777;
    step();
    chk("ar_pend_clr_valid", mem_valid, 1);
    chk("ar_pend_clr_alu", alu_out, 16'h0777);

    // halt freeze
    ex_halt = 1;
    step();
    chk("h_HALT", HALT, 1);
    chk("h_halted", halted, 1);
    ex_halt = 0; ex_mem_en = 1; ex_mem_wr = 1;
    step();
    chk("h_HALT_gone", HALT, 0);
    chk("h_mem_en", mem_en, 0);
    chk("h_mem_wr", mem_wr, 0);
    chk("h_valid", mem_valid, 0);
    chk("h_sticky", halted, 1);
    step();
    chk("h_mem_en2", mem_en, 0);
    chk("h_sticky2", halted, 1);
    rst = 0;
    #1;
    chk("h_rst_halted", halted, 0);
    #1;
    rst = 1;
    step();
    chk("h_rst_resume", mem_en, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
Pipeline register between the execute stage and the memory stage of the 16-bit pipelined core. It captures ALU result, flags, store data and memory/writeback controls from execute, and presents them to the memory stage one cycle later. It supports stall (hold), flush (bubble insertion, including flush deferred across a stall), halt freeze, and store-data bypass from writeback.

Parameters:
DW, 16, datapath width (ALU result, store data, PC+2)
RW, 3, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  memory-stage stall; hold register contents
flush  in  1  kill the instruction being loaded from execute
ex_valid  in  1  execute stage holds a real instruction
ex_alu_out  in  DW  ALU result / memory address
ex_zero  in  1  ALU zero flag
ex_ofl  in  1  ALU overflow flag
ex_r2  in  DW  store data read in decode
ex_rs2  in  RW  register index of store data
ex_mem_en  in  1  memory access
ex_mem_wr  in  1  memory write (store)
ex_reg_wr  in  1  writes register file
ex_rd  in  RW  destination register
ex_halt  in  1  HALT instruction
ex_pc2  in  DW  PC+2 of the instruction
wb_reg_wr  in  1  writeback stage writes a register this cycle
wb_rd  in  RW  writeback destination
wb_data  in  DW  writeback data
mem_valid  out  1  memory stage holds a real instruction
alu_out  out  DW  registered ALU result
alu_zero  out  1  registered zero flag
alu_ofl  out  1  registered overflow flag
r2  out  DW  registered (bypassed) store data
mem_en  out  1  memory enable, gated by mem_valid
mem_wr  out  1  memory write, gated by mem_valid
reg_wr  out  1  register write, gated by mem_valid
rd  out  RW  destination register
HALT  out  1  valid HALT in memory stage (createdump)
pc2  out  DW  registered PC+2
halted  out  1  sticky: a HALT has been captured

Behaviour:
- Reset (rst=0, async): all data registers 0, mem_valid=0, flush_pend=0, halted=0; every output 0.
- Latency: 1 cycle; execute values on edge N are visible on outputs after edge N.
- Load condition each edge, in priority order:
  1. stall=1: hold all registers. If flush=1, set flush_pend=1.
  2. stall=0 and (flush=1 or flush_pend=1 or halted=1): load a bubble (mem_valid=0, all controls 0, data fields don't-care but driven 0). Clear flush_pend.
  3. Otherwise: load execute fields, mem_valid=ex_valid.
- Controls are stored as ex_* AND ex_valid. Outputs mem_en, mem_wr, reg_wr and HALT are additionally ANDed with mem_valid.
- Halt freeze: on a load with ex_valid=1 and ex_halt=1, set halted=1 on the same edge. halted stays 1 until reset.
  - All later loads are bubbles.
  - HALT is high while that instruction sits in the register (1 cycle if no stall, longer if stalled).
- Store bypass at load: if ex_mem_en, ex_mem_wr, wb_reg_wr and wb_rd==ex_rs2 are all true, capture wb_data into r2; otherwise capture ex_r2.
- Stall refresh: while stall=1, mem_valid=1 and the held instruction is a store, if wb_reg_wr and wb_rd==held rs2, r2 is updated with wb_data. The held rs2 is stored internally. No other field changes during stall.
- flush and stall together: the instruction currently held is preserved. The bubble replaces the next load.
- Reset mid-stall or mid-flush clears flush_pend and halted immediately.

Decomposition:
- Shared package cpu_pkg: DW and RW constants; a control-bundle typedef {mem_en, mem_wr, reg_wr, halt} with a zero constant CTRL_BUBBLE.
- One natural sub-module: store_bypass (combinational compare/select of wb_data vs r2), instantiated once for the load path and once for the stall-refresh path.

Test Plan:
- Reset: drive rst=0 mid-run with valid data -> all outputs 0 immediately (asynchronously), halted=0.
- Pass-through: ex_valid=1, ex_alu_out=0x1234, ex_mem_en=1, ex_mem_wr=0, ex_rd=5 -> next cycle alu_out=0x1234, mem_en=1, rd=5, mem_valid=1.
- Stall, then flush during stall: load ALU=0x00AA, then stall=1 for 3 cycles with flush=1 on the 2nd cycle -> alu_out stays 0x00AA throughout. First edge after stall drops loads a bubble (mem_valid=0, mem_en=0). Following edge loads execute normally.
- Store bypass: ex_mem_en=1, ex_mem_wr=1, ex_rs2=3, ex_r2=0x1111, wb_reg_wr=1, wb_rd=3, wb_data=0xBEEF -> r2=0xBEEF. With wb_rd=4 -> r2=0x1111.
- Stall refresh: held store with rs2=2 under stall, wb writes r2 with 0x5A5A -> r2 becomes 0x5A5A next edge while alu_out is unchanged.
- Halt: ex_halt=1, ex_valid=1 -> HALT=1 for exactly one cycle and halted=1 permanently. Subsequent ex_valid=1 stores give mem_en=0, mem_wr=0 until reset.
